// File: rtl/io_level_qualifier.sv
// Debounces an already-synchronised level: commits a change after FILTER_CYCLES equal samples,
// then emits registered rise/fall strobes, a saturating rise counter and a sticky pending flag.
module io_level_qualifier #(
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 level_in,
  input  logic                 count_clr,
  input  logic                 event_ack,
  output logic                 level_out,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] event_count,
  output logic                 event_pending
);

  localparam int QW = $clog2(FILTER_CYCLES + 1);
  localparam logic [QW-1:0] QMAX = QW'(FILTER_CYCLES);

  typedef enum logic [1:0] {LOW, QUAL_HIGH, HIGH, QUAL_LOW} state_t;

  state_t        state, state_nxt;
  logic [QW-1:0] qcnt, qcnt_nxt, qcnt_inc;
  logic          rise_nxt, fall_nxt, level_nxt;

  assign qcnt_inc = qcnt + QW'(1);

  always_comb begin
    state_nxt = state;
    qcnt_nxt  = qcnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      LOW: begin
        if (level_in) begin
          if (FILTER_CYCLES == 1) begin
            state_nxt = HIGH;
            rise_nxt  = 1'b1;
          end else begin
            state_nxt = QUAL_HIGH;
            qcnt_nxt  = QW'(1);
          end
        end
      end
      QUAL_HIGH: begin
        if (!level_in) begin
          state_nxt = LOW;
          qcnt_nxt  = '0;
        end else if (qcnt_inc == QMAX) begin
          state_nxt = HIGH;
          qcnt_nxt  = '0;
          rise_nxt  = 1'b1;
        end else begin
          qcnt_nxt = qcnt_inc;
        end
      end
      HIGH: begin
        if (!level_in) begin
          if (FILTER_CYCLES == 1) begin
            state_nxt = LOW;
            fall_nxt  = 1'b1;
          end else begin
            state_nxt = QUAL_LOW;
            qcnt_nxt  = QW'(1);
          end
        end
      end
      QUAL_LOW: begin
        if (level_in) begin
          state_nxt = HIGH;
          qcnt_nxt  = '0;
        end else if (qcnt_inc == QMAX) begin
          state_nxt = LOW;
          qcnt_nxt  = '0;
          fall_nxt  = 1'b1;
        end else begin
          qcnt_nxt = qcnt_inc;
        end
      end
      default: begin
        state_nxt = LOW;
        qcnt_nxt  = '0;
      end
    endcase
  end

  // During qualification the committed level is still the one being left.
  assign level_nxt = (state_nxt == HIGH) || (state_nxt == QUAL_LOW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOW;
      qcnt       <= '0;
      level_out  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      qcnt       <= qcnt_nxt;
      level_out  <= level_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
    end
  end

  // Clear wins over increment, but a coincident rise still counts as the first event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_count <= '0;
    end else if (count_clr) begin
      event_count <= rise_nxt ? CNT_WIDTH'(1) : '0;
    end else if (rise_nxt && (event_count != '1)) begin
      event_count <= event_count + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_pending <= 1'b0;
    end else if (rise_nxt || fall_nxt) begin
      event_pending <= 1'b1;
    end else if (event_ack) begin
      event_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_level_qualifier.sv
// Three qualifier instances (F=4/W=8, F=4/W=2, F=1/W=8) on shared stimulus, checked
// every cycle against a sample-history model plus directed literal expectations.
module tb_io_level_qualifier;

  logic clk;
  logic rst_n;
  logic level_in;
  logic count_clr;
  logic event_ack;
  logic chk_en;

  logic       d_lvl  [3];
  logic       d_rise [3];
  logic       d_fall [3];
  logic       d_pend [3];
  logic [7:0] d_cnt0;
  logic [1:0] d_cnt1;
  logic [7:0] d_cnt2;

  int n_cmp;
  int n_bad;
  int seen_rise [3];
  int seen_fall [3];

  io_level_qualifier #(.FILTER_CYCLES(4), .CNT_WIDTH(8)) u_f4 (
    .clk(clk), .rst_n(rst_n), .level_in(level_in), .count_clr(count_clr), .event_ack(event_ack),
    .level_out(d_lvl[0]), .rise_pulse(d_rise[0]), .fall_pulse(d_fall[0]),
    .event_count(d_cnt0), .event_pending(d_pend[0]));

  io_level_qualifier #(.FILTER_CYCLES(4), .CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .level_in(level_in), .count_clr(count_clr), .event_ack(event_ack),
    .level_out(d_lvl[1]), .rise_pulse(d_rise[1]), .fall_pulse(d_fall[1]),
    .event_count(d_cnt1), .event_pending(d_pend[1]));

  io_level_qualifier #(.FILTER_CYCLES(1), .CNT_WIDTH(8)) u_f1 (
    .clk(clk), .rst_n(rst_n), .level_in(level_in), .count_clr(count_clr), .event_ack(event_ack),
    .level_out(d_lvl[2]), .rise_pulse(d_rise[2]), .fall_pulse(d_fall[2]),
    .event_count(d_cnt2), .event_pending(d_pend[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int fc(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic int mc(input int i);
    return (i == 1) ? 3 : 255;
  endfunction

  function automatic int dcnt(input int i);
    if (i == 0) return int'(d_cnt0);
    if (i == 1) return int'(d_cnt1);
    return int'(d_cnt2);
  endfunction

  // Model: the level flips once the last F samples since reset all disagree with it.
  typedef struct {
    logic [255:0] h;
    int           nv;
    logic         lvl;
    logic         rise;
    logic         fall;
    logic         pend;
    int           cnt;
  } mstate_t;

  mstate_t m [3];

  function automatic mstate_t mzero();
    mstate_t z;
    z.h = '0; z.nv = 0; z.lvl = 1'b0; z.rise = 1'b0; z.fall = 1'b0; z.pend = 1'b0; z.cnt = 0;
    return z;
  endfunction

  function automatic mstate_t mstep(input mstate_t s, input int f, input int mx,
                                    input logic lin, input logic clr, input logic ack);
    mstate_t n;
    bit flip;
    n = s;
    n.h  = {s.h[254:0], lin};
    n.nv = (s.nv < 256) ? s.nv + 1 : 256;
    flip = (n.nv >= f);
    for (int k = 0; k < f; k++) if (n.h[k] == s.lvl) flip = 1'b0;
    n.rise = flip && !s.lvl;
    n.fall = flip && s.lvl;
    n.lvl  = s.lvl ^ flip;
    if (clr) n.cnt = n.rise ? 1 : 0;
    else if (n.rise && s.cnt < mx) n.cnt = s.cnt + 1;
    if (n.rise || n.fall) n.pend = 1'b1;
    else if (ack) n.pend = 1'b0;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) m[i] <= mzero();
    end else begin
      for (int i = 0; i < 3; i++) m[i] <= mstep(m[i], fc(i), mc(i), level_in, count_clr, event_ack);
    end
  end

  task automatic chk(input string name, input int inst, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d, expected %0d at %0t", name, inst, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk("level_out", i, int'(d_lvl[i]), int'(m[i].lvl));
        chk("rise_pulse", i, int'(d_rise[i]), int'(m[i].rise));
        chk("fall_pulse", i, int'(d_fall[i]), int'(m[i].fall));
        chk("event_count", i, dcnt(i), m[i].cnt);
        chk("event_pending", i, int'(d_pend[i]), int'(m[i].pend));
        seen_rise[i] <= seen_rise[i] + int'(d_rise[i]);
        seen_fall[i] <= seen_fall[i] + int'(d_fall[i]);
      end
    end
  end

  task automatic cyc(input logic l, input logic c, input logic a);
    level_in  = l;
    count_clr = c;
    event_ack = a;
    @(posedge clk);
    #2;
  endtask

  int br, bf;

  initial begin
    n_cmp = 0; n_bad = 0;
    for (int i = 0; i < 3; i++) begin seen_rise[i] = 0; seen_fall[i] = 0; end
    rst_n = 1'b1; level_in = 1'b0; count_clr = 1'b0; event_ack = 1'b0; chk_en = 1'b0;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_level", 0, int'(d_lvl[0]), 0);
    chk("rst_rise", 0, int'(d_rise[0]), 0);
    chk("rst_fall", 0, int'(d_fall[0]), 0);
    chk("rst_count", 0, int'(d_cnt0), 0);
    chk("rst_pending", 0, int'(d_pend[0]), 0);
    rst_n = 1'b1;

    // Clean rise held for 10 samples, then a clean fall.
    repeat (3) cyc(1, 0, 0);
    chk("t1_pre_level", 0, int'(d_lvl[0]), 0);
    cyc(1, 0, 0);
    chk("t1_level", 0, int'(d_lvl[0]), 1);
    chk("t1_rise", 0, int'(d_rise[0]), 1);
    chk("t1_count", 0, int'(d_cnt0), 1);
    chk("t1_pending", 0, int'(d_pend[0]), 1);
    cyc(1, 0, 0);
    chk("t1_rise_once", 0, int'(d_rise[0]), 0);
    repeat (5) cyc(1, 0, 0);
    repeat (4) cyc(0, 0, 0);
    chk("t1_fall", 0, int'(d_fall[0]), 1);
    chk("t1_level_low", 0, int'(d_lvl[0]), 0);

    // Glitches of 1..3 samples must vanish; 4 samples commit.
    cyc(0, 1, 1);
    chk("t2_clr_count", 0, int'(d_cnt0), 0);
    chk("t2_ack_pending", 0, int'(d_pend[0]), 0);
    br = seen_rise[0];
    for (int g = 1; g <= 3; g++) begin
      repeat (g) cyc(1, 0, 0);
      repeat (4) cyc(0, 0, 0);
    end
    chk("t2_glitch_level", 0, int'(d_lvl[0]), 0);
    chk("t2_glitch_count", 0, int'(d_cnt0), 0);
    chk("t2_glitch_pending", 0, int'(d_pend[0]), 0);
    chk("t2_glitch_strobes", 0, seen_rise[0] - br, 0);
    repeat (4) cyc(1, 0, 0);
    chk("t2_rise", 0, int'(d_rise[0]), 1);
    chk("t2_count", 0, int'(d_cnt0), 1);
    repeat (2) cyc(1, 0, 0);
    chk("t2_single_rise", 0, seen_rise[0] - br, 1);

    // Five full periods: 2-bit counter saturates at 3.
    cyc(1, 1, 0);
    br = seen_rise[1];
    bf = seen_fall[1];
    repeat (5) begin
      repeat (4) cyc(0, 0, 0);
      repeat (4) cyc(1, 0, 0);
    end
    cyc(1, 0, 0);
    chk("t3_sat_count", 1, int'(d_cnt1), 3);
    chk("t3_wide_count", 0, int'(d_cnt0), 5);
    chk("t3_rises", 1, seen_rise[1] - br, 5);
    chk("t3_falls", 1, seen_fall[1] - bf, 5);

    // Event beats ack; clear with a coincident rise yields 1.
    repeat (4) cyc(0, 0, 0);
    cyc(0, 0, 1);
    chk("t4_ack_alone", 0, int'(d_pend[0]), 0);
    repeat (3) cyc(1, 0, 0);
    cyc(1, 1, 1);
    chk("t4_rise", 0, int'(d_rise[0]), 1);
    chk("t4_pend_wins", 0, int'(d_pend[0]), 1);
    chk("t4_clr_rise", 0, int'(d_cnt0), 1);
    chk("t4_clr_rise_sat", 1, int'(d_cnt1), 1);
    cyc(1, 0, 1);
    chk("t4_ack_clears", 0, int'(d_pend[0]), 0);

    // Reset after two qualifying samples discards the partial count.
    repeat (4) cyc(0, 0, 0);
    repeat (2) cyc(1, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_level", 0, int'(d_lvl[0]), 0);
    chk("t5_rst_pending", 0, int'(d_pend[0]), 0);
    chk("t5_rst_count", 0, int'(d_cnt0), 0);
    chk("t5_rst_f1_level", 2, int'(d_lvl[2]), 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) cyc(1, 0, 0);
    chk("t5_no_early_rise", 0, int'(d_rise[0]), 0);
    chk("t5_level_still_low", 0, int'(d_lvl[0]), 0);
    cyc(1, 0, 0);
    chk("t5_rise_after_4", 0, int'(d_rise[0]), 1);
    chk("t5_level_high", 0, int'(d_lvl[0]), 1);

    // FILTER_CYCLES=1 follows the input with one cycle of latency.
    cyc(0, 0, 0);
    chk("t6_f1_level_low", 2, int'(d_lvl[2]), 0);
    chk("t6_f1_fall", 2, int'(d_fall[2]), 1);
    cyc(1, 0, 0);
    chk("t6_f1_level_high", 2, int'(d_lvl[2]), 1);
    chk("t6_f1_rise", 2, int'(d_rise[2]), 1);
    cyc(1, 0, 0);
    chk("t6_f1_rise_once", 2, int'(d_rise[2]), 0);
    br = seen_rise[2];
    bf = seen_fall[2];
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("t6_f1_rises", 2, seen_rise[2] - br, 2);
    chk("t6_f1_falls", 2, seen_fall[2] - bf, 2);
    chk("t6_f4_ignores", 0, int'(d_lvl[0]), 1);

    repeat (2) cyc(0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_level_qualifier.md
# io_level_qualifier

Qualifies a single-bit level that has already been brought into the local clock domain by the two-flop synchroniser, and turns it into clean events. Rejects pulses shorter than FILTER_CYCLES, emits one-cycle rise/fall strobes and a qualified level, counts rising events, and holds a sticky pending flag until software or the control FSM acknowledges it. Sits directly downstream of the synchroniser output on the FMC151 status and trigger lines, in the synchroniser's destination clock domain.

## Interface

Parameters:
- FILTER_CYCLES, default 4: consecutive equal samples required to commit a level change; legal range 1..255.
- CNT_WIDTH, default 8: width of the rising-event counter; minimum 1.

Ports:
- clk  input  1: destination-domain clock, the same clock that drives the synchroniser's output stage.
- rst_n  input  1: reset, asynchronous assert, active-low.
- level_in  input  1: synchronised level. Sampled on every rising clk edge.
- count_clr  input  1: synchronous clear of event_count.
- event_ack  input  1: clears event_pending.
- level_out  output  1: qualified (filtered) level.
- rise_pulse  output  1: one-cycle strobe on a committed 0→1 transition.
- fall_pulse  output  1: one-cycle strobe on a committed 1→0 transition.
- event_count  output  CNT_WIDTH: saturating count of rise_pulse strobes.
- event_pending  output  1: sticky flag, set by any rise_pulse or fall_pulse.

## Operation

- FSM states:
  - LOW: level_out=0.
  - QUAL_HIGH: candidate 1, level_out=0.
  - HIGH: level_out=1.
  - QUAL_LOW: candidate 0, level_out=1.
- Internal qualification counter of ceil(log2(FILTER_CYCLES+1)) bits.
- LOW:
  - level_in=1 with FILTER_CYCLES=1 → HIGH.
  - level_in=1 otherwise → QUAL_HIGH with counter=1.
  - level_in=0 → stay.
- QUAL_HIGH:
  - level_in=0 → LOW, counter cleared.
  - level_in=1 → counter+1. When the counter reaches FILTER_CYCLES → HIGH.
- HIGH and QUAL_LOW mirror LOW and QUAL_HIGH with the polarity inverted.
- A committed transition into HIGH asserts rise_pulse for exactly one cycle. A committed transition into LOW asserts fall_pulse for exactly one cycle. Both strobes are never high together.
- event_count:
  - Increments on rise_pulse and saturates at 2^CNT_WIDTH−1.
  - count_clr has priority: count_clr together with rise_pulse gives 1.
  - count_clr alone gives 0.
- event_pending:
  - Set by rise_pulse or fall_pulse.
  - Cleared by event_ack.
  - A set and an ack in the same cycle leaves it set (the event wins).
- All outputs are registered. No combinational path from input to output.

## Timing

- Reset values: state LOW, counter 0, level_out 0, rise_pulse 0, fall_pulse 0, event_count 0, event_pending 0.
- Reset is asserted asynchronously and deasserts into normal operation on the first clk edge with rst_n=1.
- Latency: level_out changes on the FILTER_CYCLES-th consecutive rising edge at which level_in is sampled at the new value. The strobe is high during the following cycle, coincident with the level_out change.
- A glitch of FILTER_CYCLES−1 or fewer samples produces no strobe, no level_out change and no counter or pending update.
- Reset during qualification drops to LOW and discards the partial count.
- If level_in=1 at reset release, qualification restarts and rise_pulse fires FILTER_CYCLES edges later.
- event_count and event_pending reflect a strobe on the same edge that registers the strobe.
- event_ack and count_clr take effect on the next edge with no latency.

## Test plan

- FILTER_CYCLES=4, level_in 0→1 held for 10 cycles → level_out=1 on the 4th sampled edge, rise_pulse high for 1 cycle, event_count=1, event_pending=1.
- Glitches of 1, 2 and 3 high samples separated by ≥4 lows → level_out stays 0, no strobes, event_count=0. Then 4 highs → a single rise_pulse.
- With CNT_WIDTH=2, 5 full high/low cycles → event_count saturates at 3, and 5 rise_pulse plus 5 fall_pulse strobes are observed.
- Drive rise_pulse and event_ack in the same cycle → event_pending stays 1. Drive rise_pulse and count_clr in the same cycle → event_count=1. Drive event_ack alone → event_pending=0 next cycle.
- Assert rst_n low mid-qualification (after 2 high samples) with level_in held high → all outputs 0 during reset. After release, rise_pulse fires exactly 4 edges later.
- FILTER_CYCLES=1 → level_out follows level_in with 1-cycle latency, and every transition produces a strobe.
